// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode encoding, FSM states and
// the opcode-class helper used by the issue logic.
package alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD    = 5'h00,
        OP_SUB    = 5'h01,
        OP_SLL    = 5'h02,
        OP_SLT    = 5'h03,
        OP_SLTU   = 5'h04,
        OP_XOR    = 5'h05,
        OP_SRL    = 5'h06,
        OP_SRA    = 5'h07,
        OP_OR     = 5'h08,
        OP_AND    = 5'h09,
        OP_MUL    = 5'h10,
        OP_MULH   = 5'h11,
        OP_MULHSU = 5'h12,
        OP_MULHU  = 5'h13,
        OP_DIV    = 5'h14,
        OP_DIVU   = 5'h15,
        OP_REM    = 5'h16,
        OP_REMU   = 5'h17
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    // Opcodes 0x10..0x17 belong to the multiply/divide unit.
    function automatic logic is_iter_op(input logic [4:0] op);
        return (op[4:3] == 2'b10);
    endfunction

    // Divide/remainder subset of the iterative class (0x14..0x17).
    function automatic logic is_div_op(input logic [4:0] op);
        return (op[4:2] == 3'b101);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Bit-serial multiply / restoring divide. Works on unsigned magnitudes;
// the sign correction is applied combinationally to the final step so the
// parent can register a finished result on the same edge it leaves BUSY.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int data_width = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  start,
    input  logic [4:0]            op,
    input  logic [data_width-1:0] rs1,
    input  logic [data_width-1:0] rs2,
    output logic                  done,
    output logic [data_width-1:0] result
);

    localparam int cnt_width = $clog2(data_width) + 1;
    localparam int w = data_width;

    logic [cnt_width-1:0] cnt;
    logic [2*w-1:0]       acc;       // mul: {partial_hi, multiplier}; div: {rem, quotient}
    logic [w-1:0]         b_mag;     // multiplicand / divisor magnitude
    logic [4:0]           op_q;
    logic                 neg_q;     // negate the selected result half

    logic                 a_signed, b_signed, sa, sb;
    logic [w-1:0]         a_mag_in, b_mag_in;
    logic                 neg_in;
    logic [w:0]           mul_sum;
    logic [w:0]           trial;
    logic [2*w-1:0]       mul_next, div_next, acc_next, prod;
    logic [w-1:0]         quo, rem;

    // Decode signedness and magnitudes of the operands presented at start.
    always_comb begin
        a_signed = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
                   (op == OP_DIV) || (op == OP_REM);
        b_signed = (op == OP_MUL) || (op == OP_MULH) ||
                   (op == OP_DIV) || (op == OP_REM);
        sa       = a_signed & rs1[w-1];
        sb       = b_signed & rs2[w-1];
        a_mag_in = sa ? (~rs1 + 1'b1) : rs1;
        b_mag_in = sb ? (~rs2 + 1'b1) : rs2;
        // Remainder takes the dividend's sign; everything else the XOR.
        if ((op == OP_REM) || (op == OP_REMU))
            neg_in = sa;
        else
            neg_in = sa ^ sb;
    end

    // One shift-add or one restoring subtract-shift step.
    always_comb begin
        mul_sum  = {1'b0, acc[2*w-1:w]} + (acc[0] ? {1'b0, b_mag} : '0);
        mul_next = {mul_sum, acc[w-1:1]};
        trial    = {acc[2*w-1:w], acc[w-1]} - {1'b0, b_mag};
        if (!trial[w])
            div_next = {trial[w-1:0], acc[w-2:0], 1'b1};
        else
            div_next = {acc[2*w-2:w], acc[w-1], acc[w-2:0], 1'b0};
        acc_next = is_div_op(op_q) ? div_next : mul_next;
    end

    // Sign-correct and select the result from the post-step accumulator.
    always_comb begin
        prod   = neg_q ? (~acc_next + 1'b1) : acc_next;
        quo    = acc_next[w-1:0];
        rem    = acc_next[2*w-1:w];
        result = '0;
        case (op_q)
            OP_MUL:                       result = prod[w-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result = prod[2*w-1:w];
            OP_DIV, OP_DIVU:              result = neg_q ? (~quo + 1'b1) : quo;
            OP_REM, OP_REMU:              result = neg_q ? (~rem + 1'b1) : rem;
            default:                      result = '0;
        endcase
    end

    // The step taken while the counter is 1 is the last one.
    always_comb begin
        done = (cnt == cnt_width'(1));
    end

    // Operand latch, accumulator and iteration counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            acc   <= '0;
            b_mag <= '0;
            op_q  <= '0;
            neg_q <= 1'b0;
        end else if (flush) begin
            cnt   <= '0;
        end else if (start) begin
            cnt   <= cnt_width'(data_width);
            acc   <= {{w{1'b0}}, a_mag_in};
            b_mag <= b_mag_in;
            op_q  <= op;
            neg_q <= neg_in;
        end else if (cnt != '0) begin
            cnt   <= cnt - 1'b1;
            acc   <= acc_next;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle RV32I ops plus iterative RV-M mul/div.
//
// Handshake: a transfer on either side happens on a rising edge where
// valid && ready are both high. Issue inputs are sampled only on that edge;
// data is held stable from out_valid rising until its handshake.
module alu_seq
    import alu_pkg::*;
#(
    parameter int data_width = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4:0]            alu_in,
    input  logic [data_width-1:0] data_rs1,
    input  logic [data_width-1:0] data_rs2,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [data_width-1:0] data,
    output logic                  busy
);

    localparam int shamt_width = $clog2(data_width);
    localparam logic [data_width-1:0] most_neg = {1'b1, {(data_width-1){1'b0}}};

    alu_state_e            state, state_next;
    logic [data_width-1:0] data_q;
    logic [data_width-1:0] alu_result, fast_result, issue_result;
    logic [data_width-1:0] mdu_result;
    logic                  mdu_done;
    logic                  accept, iter_op, div_zero, div_ovf, fast_path, start;
    logic [shamt_width-1:0] shamt;

    // Issue-side decode: what kind of op is being accepted this cycle.
    always_comb begin
        accept    = in_valid && (state == ST_IDLE) && !flush;
        iter_op   = is_iter_op(alu_in);
        div_zero  = is_div_op(alu_in) && (data_rs2 == '0);
        div_ovf   = ((alu_in == OP_DIV) || (alu_in == OP_REM)) &&
                    (data_rs1 == most_neg) && (data_rs2 == '1);
        fast_path = div_zero || div_ovf;
        start     = accept && iter_op && !fast_path;
        shamt     = data_rs2[shamt_width-1:0];
    end

    // Single-cycle datapath; unknown opcodes yield zero.
    always_comb begin
        alu_result = '0;
        case (alu_in)
            OP_ADD:  alu_result = data_rs1 + data_rs2;
            OP_SUB:  alu_result = data_rs1 - data_rs2;
            OP_SLL:  alu_result = data_rs1 << shamt;
            OP_SLT:  alu_result = {{(data_width-1){1'b0}}, ($signed(data_rs1) < $signed(data_rs2))};
            OP_SLTU: alu_result = {{(data_width-1){1'b0}}, (data_rs1 < data_rs2)};
            OP_XOR:  alu_result = data_rs1 ^ data_rs2;
            OP_SRL:  alu_result = data_rs1 >> shamt;
            OP_SRA:  alu_result = $signed(data_rs1) >>> shamt;
            OP_OR:   alu_result = data_rs1 | data_rs2;
            OP_AND:  alu_result = data_rs1 & data_rs2;
            default: alu_result = '0;
        endcase
    end

    // Divide fast paths: divide-by-zero wins over signed overflow.
    always_comb begin
        fast_result = '0;
        if (div_zero) begin
            if ((alu_in == OP_DIV) || (alu_in == OP_DIVU))
                fast_result = '1;
            else
                fast_result = data_rs1;
        end else if (div_ovf) begin
            if (alu_in == OP_DIV)
                fast_result = data_rs1;
            else
                fast_result = '0;
        end
        issue_result = iter_op ? fast_result : alu_result;
    end

    alu_muldiv_iter #(
        .data_width(data_width)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (flush),
        .start  (start),
        .op     (alu_in),
        .rs1    (data_rs1),
        .rs2    (data_rs2),
        .done   (mdu_done),
        .result (mdu_result)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // FSM next-state logic; flush overrides everything.
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (accept) state_next = start ? ST_BUSY : ST_DONE;
                ST_BUSY: if (mdu_done) state_next = ST_DONE;
                ST_DONE: if (out_ready) state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        in_ready  = (state == ST_IDLE);
        busy      = (state == ST_BUSY);
        out_valid = (state == ST_DONE);
        data      = data_q;
    end

    // Result register: loaded on a single-cycle accept or the final mul/div step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            data_q <= '0;
        else if (flush)
            data_q <= '0;
        else if (accept && !start)
            data_q <= issue_result;
        else if ((state == ST_BUSY) && mdu_done)
            data_q <= mdu_result;
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed + random bench for alu_seq with an expected-result queue.
module tb_alu_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [4:0]   alu_in = '0;
    logic [W-1:0] data_rs1 = '0;
    logic [W-1:0] data_rs2 = '0;
    logic         flush = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] data;
    logic         busy;

    logic [W-1:0] exp_q[$];
    int passed = 0;
    int total  = 0;

    alu_seq #(.data_width(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_in    (alu_in),
        .data_rs1  (data_rs1),
        .data_rs2  (data_rs2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data      (data),
        .busy      (busy)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Independent reference model.
    function automatic logic [W-1:0] ref_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] p;
        logic [4:0]  sh;
        sh = b[4:0];
        case (op)
            5'h00: return a + b;
            5'h01: return a - b;
            5'h02: return a << sh;
            5'h03: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'h04: return (a < b) ? 32'd1 : 32'd0;
            5'h05: return a ^ b;
            5'h06: return a >> sh;
            5'h07: return $signed(a) >>> sh;
            5'h08: return a | b;
            5'h09: return a & b;
            5'h10: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            5'h11: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            5'h12: begin p = {{32{a[31]}}, a} * {32'd0, b}; return p[63:32]; end
            5'h13: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            5'h14: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return $signed(a) / $signed(b);
            end
            5'h15: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'h16: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return $signed(a) % $signed(b);
            end
            5'h17: return (b == 0) ? a : a % b;
            default: return '0;
        endcase
    endfunction

    // Driver + monitor for one transaction: issue, measure latency/busy,
    // pop expected, compare, then complete the output handshake.
    task automatic do_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp, input int exp_lat, input string name);
        int lat;
        int busy_cnt;
        logic [W-1:0] e;
        exp_q.push_back(exp);
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) $display("FAIL %s in_ready: got %b want 1", name, in_ready);
        else passed++;
        in_valid = 1'b1; alu_in = op; data_rs1 = a; data_rs2 = b;
        @(posedge clk); #1;
        in_valid = 1'b0; alu_in = $urandom_range(31, 0); data_rs1 = $urandom; data_rs2 = $urandom;
        lat = 1; busy_cnt = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        total++;
        if (lat !== exp_lat) $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
        else passed++;
        total++;
        if (busy_cnt !== exp_lat - 1) $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_cnt, exp_lat - 1);
        else passed++;
        e = exp_q.pop_front();
        total++;
        if (data !== e) $display("FAIL %s data: got %h want %h", name, data, e);
        else passed++;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
        total++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++;
        if (data !== '0) $display("FAIL reset_data: got %h want 0", data); else passed++;
    endtask

    task automatic test_single_cycle();
        do_op(5'h00, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1, "add_wrap");
        do_op(5'h07, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1, "sra_shamt");
        do_op(5'h01, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1, "sub_wrap");
        do_op(5'h03, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1, "slt_neg");
        do_op(5'h04, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, "sltu");
        do_op(5'h06, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 1, "srl_shamt");
        do_op(5'h02, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 1, "sll_31");
        do_op(5'h0A, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 1, "illegal_op");
        for (int i = 0; i < 8; i++) begin
            logic [4:0] op;
            logic [W-1:0] a, b;
            op = 5'($urandom_range(9, 0));
            a = $urandom; b = $urandom;
            do_op(op, a, b, ref_op(op, a, b), 1, "rand_alu");
        end
    endtask

    task automatic test_mul();
        do_op(5'h10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, "mul");
        do_op(5'h13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu");
        do_op(5'h11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, "mulh");
        do_op(5'h12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mulhsu");
    endtask

    task automatic test_div();
        do_op(5'h14, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div_neg");
        do_op(5'h16, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem_neg");
        do_op(5'h15, 32'd100, 32'd7, 32'd14, 33, "divu");
        do_op(5'h17, 32'd100, 32'd7, 32'd2, 33, "remu");
    endtask

    task automatic test_fast_path();
        do_op(5'h15, 32'd7, 32'd0, 32'hFFFF_FFFF, 1, "divu_by0");
        do_op(5'h16, 32'd7, 32'd0, 32'd7, 1, "rem_by0");
        do_op(5'h14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
        do_op(5'h16, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, "rem_ovf");
    endtask

    task automatic test_random_iter();
        for (int i = 0; i < 6; i++) begin
            logic [4:0] op;
            logic [W-1:0] a, b;
            op = 5'($urandom_range(23, 16));
            a = $urandom; b = $urandom;
            if (i == 5) b = $urandom_range(20, 1);
            do_op(op, a, b, ref_op(op, a, b), 33, "rand_iter");
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held;
        int wait_cnt;
        exp_q.push_back(32'h0000_0F0F);
        @(negedge clk);
        in_valid = 1'b1; alu_in = 5'h05; data_rs1 = 32'h0000_FFFF; data_rs2 = 32'h0000_F0F0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_cnt = 0;
        while (out_valid !== 1'b1 && wait_cnt < 50) begin
            @(posedge clk); #1; wait_cnt++;
        end
        held = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            total++;
            if (out_valid !== 1'b1 || data !== held || in_ready !== 1'b0)
                $display("FAIL bp_hold%0d: got v=%b d=%h r=%b want v=1 d=%h r=0", i, out_valid, data, in_ready, held);
            else passed++;
            @(posedge clk); #1;
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL bp_release: got r=%b v=%b want r=1 v=0", in_ready, out_valid);
        else passed++;
        do_op(5'h08, 32'hA000_0000, 32'h0000_000A, 32'hA000_000A, 1, "bp_back_to_back");
    endtask

    task automatic test_flush();
        int seen;
        @(negedge clk);
        in_valid = 1'b1; alu_in = 5'h14; data_rs1 = 32'd1000; data_rs2 = 32'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        in_valid = 1'b1; alu_in = 5'h00; data_rs1 = 32'd1; data_rs2 = 32'd1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL flush_idle: got r=%b b=%b v=%b want r=1 b=0 v=0", in_ready, busy, out_valid);
        else passed++;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        total++;
        if (seen !== 0) $display("FAIL flush_no_valid: got %0d valid cycles want 0", seen);
        else passed++;
        do_op(5'h15, 32'd1000, 32'd3, 32'd333, 33, "after_flush");
    endtask

    task automatic test_reset_mid_busy();
        @(negedge clk);
        in_valid = 1'b1; alu_in = 5'h13; data_rs1 = 32'hDEAD_BEEF; data_rs2 = 32'h1234_5678;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || data !== '0)
            $display("FAIL async_reset: got b=%b v=%b d=%h want 0 0 0", busy, out_valid, data);
        else passed++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL reset_release: got r=%b b=%b want r=1 b=0", in_ready, busy);
        else passed++;
        do_op(5'h17, 32'd100, 32'd9, 32'd1, 33, "after_reset");
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_single_cycle();
        test_mul();
        test_div();
        test_fast_path();
        test_random_iter();
        test_backpressure();
        test_flush();
        test_reset_mid_busy();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the combinational integer ALU.
- Executes the base RV32I-style ALU ops with a registered single-cycle result.
- Adds iterative RV-M multiply and divide: one bit per cycle, with fast paths for divide-by-zero and signed overflow.
- Sits between the decode/issue stage and writeback. Issue drives one op per valid/ready handshake; writeback consumes one result per valid/ready handshake.

Parameters:
- data_width, 32: operand and result width; must be a power of two, >= 8.
- shamt_width, $clog2(data_width): localparam; shift-amount bits used from data_rs2.
- cnt_width, $clog2(data_width)+1: localparam; iteration counter width.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  block can accept a request.
- alu_in  input  5  opcode.
- data_rs1  input  data_width  operand A.
- data_rs2  input  data_width  operand B.
- flush  input  1  synchronous abort of any in-flight or held operation.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- data  output  data_width  result.
- busy  output  1  high in BUSY state.

Behaviour:
- Opcodes 0x00..0x09, single-cycle class:
  - 0x00 ADD; 0x01 SUB; 0x02 SLL; 0x03 SLT (signed); 0x04 SLTU; 0x05 XOR.
  - 0x06 SRL; 0x07 SRA (true arithmetic shift, sign-filled); 0x08 OR; 0x09 AND.
- Opcodes 0x10..0x17, iterative class:
  - 0x10 MUL (low half); 0x11 MULH (s*s); 0x12 MULHSU (rs1 signed, rs2 unsigned); 0x13 MULHU.
  - 0x14 DIV; 0x15 DIVU; 0x16 REM; 0x17 REMU.
- Any other opcode: single-cycle class, result 0.
- Shifts use data_rs2[shamt_width-1:0] only; upper bits are ignored. SLT/SLTU return 1 or 0, zero-extended. All add/sub results wrap modulo 2^data_width.
- Operands and opcode are captured only on accept (in_valid && in_ready). Inputs are don't-care at all other times.
- FSM states: IDLE, BUSY, DONE.
  - in_ready = (state == IDLE). No accept is possible while BUSY or DONE.
  - IDLE, accept of a single-cycle op or a fast-path op -> DONE. The result is registered, so out_valid rises on the cycle after accept.
  - IDLE, accept of a general iterative op -> BUSY. Operand magnitudes, result signs and opcode are latched; counter = data_width.
  - BUSY: one shift-add (mul) or one restoring subtract-shift (div) step per cycle; counter decrements. When the counter reaches 0 -> DONE.
  - Iterative latency: accept-to-out_valid = data_width+1 cycles.
  - DONE: out_valid=1. data is stable until out_valid && out_ready, then -> IDLE. The next accept is possible in the cycle after the handshake.
- Signed handling:
  - Multiply and divide run on unsigned magnitudes.
  - Final correction is applied on the DONE transition.
  - Product: 2*data_width bits, negated if operand signs differ (signed views only).
  - Quotient sign = sign(rs1) XOR sign(rs2).
  - Remainder sign = sign(rs1).
- Fast paths (single-cycle latency, no BUSY):
  - Divisor == 0: DIV/DIVU -> all ones; REM/REMU -> data_rs1.
  - DIV with rs1 = most-negative value and rs2 = -1: result = rs1. REM with the same operands: result = 0.
- flush=1: the next state is IDLE from any state; out_valid=0 next cycle; the in-flight result is discarded. If flush and in_valid coincide, flush wins and nothing is accepted.
- Reset (async, any state including mid-BUSY): state=IDLE, out_valid=0, busy=0, data=0, counter=0, all datapath registers 0. in_ready=1 after reset.
- out_ready is ignored unless out_valid=1.

Decomposition:
- Shared package alu_pkg holds:
  - alu_op_e enum (5-bit), with the opcode values listed above.
  - State enum alu_state_e.
  - Helper function is_iter_op().
- Natural sub-module: alu_muldiv_iter. It holds the counter, the 2*data_width accumulator/remainder registers, and the sign-correction logic. It exposes start / done / result to the alu_seq FSM.
- The single-cycle ALU datapath stays inline in alu_seq.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001 -> data=0x80000000, out_valid exactly 1 cycle after accept; SRA 0x80000000 by rs2=0x24 -> 0xF8000000 (shift 4 used).
- rs1=rs2=0xFFFFFFFF:
  - MUL -> 0x00000001; MULHU -> 0xFFFFFFFE; MULH -> 0x00000000; MULHSU -> 0xFFFFFFFF.
  - Each with out_valid at accept+33; busy high for 32 cycles.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2. All at accept+33.
- Fast paths, each out_valid at accept+1:
  - DIVU 7/0 -> 0xFFFFFFFF; REM 7/0 -> 7.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> data and out_valid stable, in_ready=0; out_ready=1 -> IDLE next cycle, back-to-back op accepted.
- Abort and reset:
  - flush at cycle 10 of a DIV -> IDLE next cycle, no out_valid, next op result correct.
  - rst_n low mid-BUSY -> outputs 0 immediately (async), in_ready=1 after release.
